// File: rtl/altera_tse_reset_seq_pkg.sv
// Shared state encodings and counter sizing helpers for the transceiver reset sequencer.
package altera_tse_reset_seq_pkg;

   typedef enum logic [1:0] {
      TxPllPd,
      TxWaitLock,
      TxReady,
      TxDigPulse
   } tx_state_t;

   typedef enum logic [2:0] {
      RxWaitTx,
      RxOc,
      RxWaitLtd,
      RxLtdHold,
      RxReady,
      RxDigPulse
   } rx_state_t;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Terminal count for an N-cycle hold; a zero-length hold still lasts one cycle.
   function automatic int unsigned last_cnt(input int unsigned n);
      return (n > 0) ? n - 1 : 0;
   endfunction

endpackage

// File: rtl/altera_tse_rx_reset_chan.sv
// Per-channel RX reset FSM: offset cancellation, CDR lock-to-data hold, recovery and digital pulses.
module altera_tse_rx_reset_chan
   import altera_tse_reset_seq_pkg::*;
#(
   parameter int unsigned T_LTD           = 8,
   parameter int unsigned OC_TAIL_CYCLES  = 2,
   parameter int unsigned DIG_HOLD_CYCLES = 3
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tx_done,
   input  logic i_oc_busy,
   input  logic i_locked_to_data,
   input  logic i_manual,
   input  logic i_dig_req,
   output logic o_analogreset,
   output logic o_digitalreset,
   output logic o_ready
);

   localparam int unsigned CNT_MAX = max2(T_LTD, max2(OC_TAIL_CYCLES, DIG_HOLD_CYCLES));
   localparam int unsigned CW      = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
   localparam logic [CW-1:0] OC_LAST  = CW'(last_cnt(OC_TAIL_CYCLES));
   localparam logic [CW-1:0] LTD_END  = CW'(T_LTD);
   localparam logic [CW-1:0] DIG_LAST = CW'(last_cnt(DIG_HOLD_CYCLES));

   rx_state_t     r_state;
   logic [CW-1:0] r_cnt;
   logic          r_analog;
   logic          r_digital;
   logic          r_ready;
   logic [CW-1:0] w_cnt_inc;

   assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= RxWaitTx;
         r_cnt     <= '0;
         r_analog  <= 1'b1;
         r_digital <= 1'b1;
         r_ready   <= 1'b0;
      end else if (!i_tx_done) begin
         // Losing the TX side overrides every channel-local event.
         r_state   <= RxWaitTx;
         r_cnt     <= '0;
         r_analog  <= 1'b1;
         r_digital <= 1'b1;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            RxWaitTx: begin
               r_state <= RxOc;
               r_cnt   <= '0;
            end
            RxOc: begin
               if (i_oc_busy) begin
                  r_cnt <= '0;
               end else if (r_cnt == OC_LAST) begin
                  r_state  <= RxWaitLtd;
                  r_analog <= 1'b0;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            RxWaitLtd: begin
               if (i_locked_to_data) begin
                  r_state <= RxLtdHold;
                  r_cnt   <= '0;
               end
            end
            RxLtdHold: begin
               if (!i_locked_to_data) begin
                  r_state <= RxWaitLtd;
                  r_cnt   <= '0;
               end else if (r_cnt == LTD_END) begin
                  r_state   <= RxReady;
                  r_digital <= 1'b0;
                  r_ready   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            RxReady: begin
               // Lock loss outranks a simultaneous digital-reset request.
               if (!i_locked_to_data && !i_manual) begin
                  r_state   <= RxWaitLtd;
                  r_digital <= 1'b1;
                  r_ready   <= 1'b0;
                  r_cnt     <= '0;
               end else if (i_dig_req) begin
                  r_state   <= RxDigPulse;
                  r_digital <= 1'b1;
                  r_ready   <= 1'b0;
                  r_cnt     <= '0;
               end
            end
            RxDigPulse: begin
               if (r_cnt == DIG_LAST) begin
                  r_state   <= RxReady;
                  r_digital <= 1'b0;
                  r_ready   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state   <= RxWaitTx;
               r_cnt     <= '0;
               r_analog  <= 1'b1;
               r_digital <= 1'b1;
               r_ready   <= 1'b0;
            end
         endcase
      end
   end

   assign o_analogreset  = r_analog;
   assign o_digitalreset = r_digital;
   assign o_ready        = r_ready;

endmodule

// File: rtl/altera_tse_xcvr_resync.sv
// Two-flop synchronizer for asynchronous transceiver status bits.
module altera_tse_xcvr_resync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/altera_tse_multi_reset_sequencer.sv
// Reset sequencer for one shared TX PLL and NUM_CHANNELS CDR auto-lock RX channels.
module altera_tse_multi_reset_sequencer
   import altera_tse_reset_seq_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS    = 4,
   parameter int unsigned SYS_CLK_IN_MHZ  = 50,
   parameter int unsigned T_PLL_PD_US     = 1,
   parameter int unsigned T_LTD_US        = 4,
   parameter int unsigned OC_TAIL_CYCLES  = 2,
   parameter int unsigned DIG_HOLD_CYCLES = 3
) (
   input  logic                    clock,
   input  logic                    reset_all,
   input  logic                    powerdown_all,
   input  logic                    reset_tx_digital,
   input  logic [NUM_CHANNELS-1:0] reset_rx_digital,
   input  logic [NUM_CHANNELS-1:0] manual_mode,
   input  logic                    pll_is_locked,
   input  logic [NUM_CHANNELS-1:0] rx_oc_busy,
   input  logic [NUM_CHANNELS-1:0] rx_is_lockedtodata,
   output logic                    pll_powerdown,
   output logic                    tx_digitalreset,
   output logic [NUM_CHANNELS-1:0] rx_analogreset,
   output logic [NUM_CHANNELS-1:0] rx_digitalreset,
   output logic                    gxb_powerdown,
   output logic                    tx_ready,
   output logic [NUM_CHANNELS-1:0] rx_ready
);

   // Outside the fitter, timers run as if clocked at (at most) 2 MHz to keep simulation short.
`ifdef ALTERA_RESERVED_QIS
   localparam int unsigned CLK_MHZ = SYS_CLK_IN_MHZ;
`else
   localparam int unsigned CLK_MHZ = (SYS_CLK_IN_MHZ < 2) ? SYS_CLK_IN_MHZ : 2;
`endif

   localparam int unsigned T_PLL  = CLK_MHZ * T_PLL_PD_US;
   localparam int unsigned T_LTD  = CLK_MHZ * T_LTD_US;
   localparam int unsigned N      = NUM_CHANNELS;
   localparam int unsigned SW     = 3 * N + 1;
   localparam int unsigned TX_MAX = max2(T_PLL, DIG_HOLD_CYCLES);
   localparam int unsigned TX_CW  = cnt_width(TX_MAX);
   localparam logic [TX_CW-1:0] TX_SAT   = TX_CW'(TX_MAX);
   localparam logic [TX_CW-1:0] PLL_LAST = TX_CW'(last_cnt(T_PLL));
   localparam logic [TX_CW-1:0] DIG_LAST = TX_CW'(last_cnt(DIG_HOLD_CYCLES));

   logic             w_rst;
   logic [SW-1:0]    w_sync;
   logic             w_pll_locked_r;
   logic [N-1:0]     w_oc_busy_r;
   logic [N-1:0]     w_ltd_r;
   logic [N-1:0]     w_manual_r;
   logic             w_tx_done;
   logic [TX_CW-1:0] w_tx_cnt_inc;

   tx_state_t        r_tx_state;
   logic [TX_CW-1:0] r_tx_cnt;
   logic             r_pll_powerdown;
   logic             r_tx_digitalreset;
   logic             r_tx_ready;

   assign w_rst         = reset_all | powerdown_all;
   assign gxb_powerdown = powerdown_all;

   altera_tse_xcvr_resync #(
      .WIDTH (SW)
   ) u_resync (
      .i_clk (clock),
      .i_rst (w_rst),
      .i_d   ({manual_mode, rx_is_lockedtodata, rx_oc_busy, pll_is_locked}),
      .o_q   (w_sync)
   );

   assign w_pll_locked_r = w_sync[0];
   assign w_oc_busy_r    = w_sync[N:1];
   assign w_ltd_r        = w_sync[2*N:N+1];
   assign w_manual_r     = w_sync[3*N:2*N+1];

   assign w_tx_cnt_inc = (r_tx_cnt == TX_SAT) ? r_tx_cnt : r_tx_cnt + 1'b1;

   always_ff @(posedge clock or posedge w_rst) begin
      if (w_rst) begin
         r_tx_state        <= TxPllPd;
         r_tx_cnt          <= '0;
         r_pll_powerdown   <= 1'b1;
         r_tx_digitalreset <= 1'b1;
         r_tx_ready        <= 1'b0;
      end else begin
         case (r_tx_state)
            TxPllPd: begin
               if (r_tx_cnt == PLL_LAST) begin
                  r_tx_state      <= TxWaitLock;
                  r_pll_powerdown <= 1'b0;
                  r_tx_cnt        <= '0;
               end else begin
                  r_tx_cnt <= w_tx_cnt_inc;
               end
            end
            TxWaitLock: begin
               if (w_pll_locked_r) begin
                  r_tx_state        <= TxReady;
                  r_tx_digitalreset <= 1'b0;
                  r_tx_ready        <= 1'b1;
               end
            end
            TxReady: begin
               if (!w_pll_locked_r) begin
                  r_tx_state        <= TxWaitLock;
                  r_tx_digitalreset <= 1'b1;
                  r_tx_ready        <= 1'b0;
               end else if (reset_tx_digital) begin
                  r_tx_state        <= TxDigPulse;
                  r_tx_digitalreset <= 1'b1;
                  r_tx_ready        <= 1'b0;
                  r_tx_cnt          <= '0;
               end
            end
            TxDigPulse: begin
               if (!w_pll_locked_r) begin
                  r_tx_state <= TxWaitLock;
               end else if (r_tx_cnt == DIG_LAST) begin
                  r_tx_state        <= TxReady;
                  r_tx_digitalreset <= 1'b0;
                  r_tx_ready        <= 1'b1;
               end else begin
                  r_tx_cnt <= w_tx_cnt_inc;
               end
            end
            default: begin
               r_tx_state        <= TxPllPd;
               r_tx_cnt          <= '0;
               r_pll_powerdown   <= 1'b1;
               r_tx_digitalreset <= 1'b1;
               r_tx_ready        <= 1'b0;
            end
         endcase
      end
   end

   // A TX digital pulse keeps the channels running; only PLL lock loss releases them.
   assign w_tx_done = (r_tx_state == TxReady) || (r_tx_state == TxDigPulse);

   assign pll_powerdown   = r_pll_powerdown;
   assign tx_digitalreset = r_tx_digitalreset;
   assign tx_ready        = r_tx_ready;

   for (genvar g = 0; g < N; g++) begin : g_chan
      altera_tse_rx_reset_chan #(
         .T_LTD           (T_LTD),
         .OC_TAIL_CYCLES  (OC_TAIL_CYCLES),
         .DIG_HOLD_CYCLES (DIG_HOLD_CYCLES)
      ) u_chan (
         .i_clk            (clock),
         .i_rst            (w_rst),
         .i_tx_done        (w_tx_done),
         .i_oc_busy        (w_oc_busy_r[g]),
         .i_locked_to_data (w_ltd_r[g]),
         .i_manual         (w_manual_r[g]),
         .i_dig_req        (reset_rx_digital[g]),
         .o_analogreset    (rx_analogreset[g]),
         .o_digitalreset   (rx_digitalreset[g]),
         .o_ready          (rx_ready[g])
      );
   end

endmodule

// File: tb/tb_altera_tse_multi_reset_sequencer.sv
// Scenario bench for the reset sequencer: 2 channels, T_PLL=2, T_LTD=8, OC tail 2, digital hold 3.
module tb_altera_tse_multi_reset_sequencer;

   localparam int N = 2;

   logic         clock = 1'b0;
   logic         reset_all = 1'b0;
   logic         powerdown_all = 1'b0;
   logic         reset_tx_digital = 1'b0;
   logic [N-1:0] reset_rx_digital = '0;
   logic [N-1:0] manual_mode = '0;
   logic         pll_is_locked = 1'b0;
   logic [N-1:0] rx_oc_busy = '0;
   logic [N-1:0] rx_is_lockedtodata = '1;
   logic         pll_powerdown, tx_digitalreset, gxb_powerdown, tx_ready;
   logic [N-1:0] rx_analogreset, rx_digitalreset, rx_ready;

   altera_tse_multi_reset_sequencer #(
      .NUM_CHANNELS    (N),
      .SYS_CLK_IN_MHZ  (50),
      .T_PLL_PD_US     (1),
      .T_LTD_US        (4),
      .OC_TAIL_CYCLES  (2),
      .DIG_HOLD_CYCLES (3)
   ) dut (
      .clock              (clock),
      .reset_all          (reset_all),
      .powerdown_all      (powerdown_all),
      .reset_tx_digital   (reset_tx_digital),
      .reset_rx_digital   (reset_rx_digital),
      .manual_mode        (manual_mode),
      .pll_is_locked      (pll_is_locked),
      .rx_oc_busy         (rx_oc_busy),
      .rx_is_lockedtodata (rx_is_lockedtodata),
      .pll_powerdown      (pll_powerdown),
      .tx_digitalreset    (tx_digitalreset),
      .rx_analogreset     (rx_analogreset),
      .rx_digitalreset    (rx_digitalreset),
      .gxb_powerdown      (gxb_powerdown),
      .tx_ready           (tx_ready),
      .rx_ready           (rx_ready)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] obs_q[$];

   function automatic void expect_val(input string name, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.val  = val;
      sb.push_back(e);
   endfunction

   // Edge timestamps (posedge count), -1 when the edge has not been seen since the last clear.
   int pd_fall, txr_rise, txr_fall, txd_rise, txd_fall;
   int an_fall[N], rr_rise[N], rr_fall[N], rd_rise[N], rd_fall[N];

   logic         p_pd = 1'b1, p_txr = 1'b0, p_txd = 1'b1;
   logic [N-1:0] p_an = '1, p_rr = '0, p_rd = '1;

   task automatic clear_events();
      pd_fall = -1; txr_rise = -1; txr_fall = -1; txd_rise = -1; txd_fall = -1;
      for (int i = 0; i < N; i++) begin
         an_fall[i] = -1; rr_rise[i] = -1; rr_fall[i] = -1; rd_rise[i] = -1; rd_fall[i] = -1;
      end
   endtask

   always @(negedge clock) begin
      if (p_pd && !pll_powerdown) pd_fall = cyc;
      if (!p_txr && tx_ready) txr_rise = cyc;
      if (p_txr && !tx_ready) txr_fall = cyc;
      if (!p_txd && tx_digitalreset) txd_rise = cyc;
      if (p_txd && !tx_digitalreset) txd_fall = cyc;
      for (int i = 0; i < N; i++) begin
         if (p_an[i] && !rx_analogreset[i]) an_fall[i] = cyc;
         if (!p_rr[i] && rx_ready[i]) rr_rise[i] = cyc;
         if (p_rr[i] && !rx_ready[i]) rr_fall[i] = cyc;
         if (!p_rd[i] && rx_digitalreset[i]) rd_rise[i] = cyc;
         if (p_rd[i] && !rx_digitalreset[i]) rd_fall[i] = cyc;
      end
      p_pd = pll_powerdown; p_txr = tx_ready; p_txd = tx_digitalreset;
      p_an = rx_analogreset; p_rr = rx_ready; p_rd = rx_digitalreset;
      // Reset-ordering invariants hold on every cycle.
      n_checks++;
      if (pll_powerdown !== 1'b0 &&
          {tx_digitalreset, rx_analogreset, rx_digitalreset} !== {(2*N+1){1'b1}})
         $display("FAIL inv_pll_pd @%0d: pd=%b txd=%b an=%b dig=%b required all resets high",
                  cyc, pll_powerdown, tx_digitalreset, rx_analogreset, rx_digitalreset);
      else n_pass++;
      n_checks++;
      if ((rx_analogreset & ~rx_digitalreset) !== '0)
         $display("FAIL inv_an_dig @%0d: an=%b dig=%b required an implies dig",
                  cyc, rx_analogreset, rx_digitalreset);
      else n_pass++;
   end

   task automatic ticks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [31:0] o;
      #2 reset_all = 1'b1;
      ticks(3);
      expect_val("rst_pll_powerdown", 1);
      expect_val("rst_tx_digitalreset", 1);
      expect_val("rst_rx_analogreset", 3);
      expect_val("rst_rx_digitalreset", 3);
      expect_val("rst_tx_ready", 0);
      expect_val("rst_rx_ready", 0);
      expect_val("rst_gxb_powerdown", 0);
      obs_q.push_back(32'(pll_powerdown));
      obs_q.push_back(32'(tx_digitalreset));
      obs_q.push_back(32'(rx_analogreset));
      obs_q.push_back(32'(rx_digitalreset));
      obs_q.push_back(32'(tx_ready));
      obs_q.push_back(32'(rx_ready));
      obs_q.push_back(32'(gxb_powerdown));
      reset_all = 1'b0;
      powerdown_all = 1'b1;
      #1;
      expect_val("pwdn_gxb_powerdown", 1);
      expect_val("pwdn_pll_powerdown", 1);
      obs_q.push_back(32'(gxb_powerdown));
      obs_q.push_back(32'(pll_powerdown));
      reset_all = 1'b1;
      powerdown_all = 1'b0;
      #1;
      expect_val("rst_gxb_low", 0);
      obs_q.push_back(32'(gxb_powerdown));
      ticks(2);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         n_checks++;
         if (o !== e.val)
            $display("FAIL %s: observed %0d required %0d", e.name, $signed(o), $signed(e.val));
         else n_pass++;
      end
   endtask

   task automatic test_bringup();
      exp_t        e;
      logic [31:0] o;
      int          t0, tl;
      clear_events();
      reset_all = 1'b0;
      t0 = cyc;
      expect_val("pll_pd_fall", t0 + 2);
      ticks(10);
      pll_is_locked = 1'b1;
      tl = cyc;
      expect_val("tx_ready_rise", tl + 3);
      expect_val("tx_dig_fall", tl + 3);
      expect_val("an0_fall", tl + 6);
      expect_val("an1_fall", tl + 6);
      expect_val("rr0_rise", tl + 16);
      expect_val("rr1_rise", tl + 16);
      ticks(30);
      obs_q.push_back(pd_fall);
      obs_q.push_back(txr_rise);
      obs_q.push_back(txd_fall);
      obs_q.push_back(an_fall[0]);
      obs_q.push_back(an_fall[1]);
      obs_q.push_back(rr_rise[0]);
      obs_q.push_back(rr_rise[1]);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         n_checks++;
         if (o !== e.val)
            $display("FAIL %s: observed %0d required %0d", e.name, $signed(o), $signed(e.val));
         else n_pass++;
      end
   endtask

   task automatic test_oc_skew();
      exp_t        e;
      logic [31:0] o;
      int          tb0;
      reset_all = 1'b1;
      rx_oc_busy = 2'b11;
      ticks(2);
      clear_events();
      reset_all = 1'b0;
      ticks(8);
      rx_oc_busy[0] = 1'b0;
      tb0 = cyc;
      expect_val("skew_an0_fall", tb0 + 4);
      expect_val("skew_rr0_rise", tb0 + 14);
      expect_val("skew_mid_rx_ready", 1);
      expect_val("skew_rr1_rise", tb0 + 34);
      expect_val("skew_rr0_no_fall", -1);
      ticks(15);
      o = 32'(rx_ready);
      ticks(5);
      rx_oc_busy[1] = 1'b0;
      ticks(20);
      obs_q.push_back(an_fall[0]);
      obs_q.push_back(rr_rise[0]);
      obs_q.push_back(o);
      obs_q.push_back(rr_rise[1]);
      obs_q.push_back(rr_fall[0]);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         n_checks++;
         if (o !== e.val)
            $display("FAIL %s: observed %0d required %0d", e.name, $signed(o), $signed(e.val));
         else n_pass++;
      end
   endtask

   task automatic test_lock_loss();
      exp_t        e;
      logic [31:0] o;
      int          tc, tr;
      clear_events();
      rx_is_lockedtodata[0] = 1'b0;
      tc = cyc;
      expect_val("ll_rd0_rise", tc + 3);
      expect_val("ll_rr0_fall", tc + 3);
      expect_val("ll_rx_ready", 2);
      ticks(5);
      obs_q.push_back(rd_rise[0]);
      obs_q.push_back(rr_fall[0]);
      obs_q.push_back(32'(rx_ready));
      rx_is_lockedtodata[0] = 1'b1;
      tr = cyc;
      expect_val("ll_rr0_recover", tr + 12);
      expect_val("ll_rr1_no_fall", -1);
      ticks(15);
      obs_q.push_back(rr_rise[0]);
      obs_q.push_back(rr_fall[1]);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         n_checks++;
         if (o !== e.val)
            $display("FAIL %s: observed %0d required %0d", e.name, $signed(o), $signed(e.val));
         else n_pass++;
      end
   endtask

   task automatic test_manual();
      exp_t        e;
      logic [31:0] o;
      manual_mode[0] = 1'b1;
      ticks(4);
      clear_events();
      rx_is_lockedtodata[0] = 1'b0;
      expect_val("man_rx_ready", 3);
      expect_val("man_rd0_no_rise", -1);
      expect_val("man_rx_digitalreset", 0);
      ticks(10);
      obs_q.push_back(32'(rx_ready));
      obs_q.push_back(rd_rise[0]);
      obs_q.push_back(32'(rx_digitalreset));
      rx_is_lockedtodata[0] = 1'b1;
      ticks(4);
      manual_mode[0] = 1'b0;
      ticks(4);
      expect_val("man_exit_rx_ready", 3);
      obs_q.push_back(32'(rx_ready));
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         n_checks++;
         if (o !== e.val)
            $display("FAIL %s: observed %0d required %0d", e.name, $signed(o), $signed(e.val));
         else n_pass++;
      end
   endtask

   task automatic test_dig_pulse();
      exp_t        e;
      logic [31:0] o;
      int          tp, tt;
      clear_events();
      reset_rx_digital[1] = 1'b1;
      tp = cyc;
      expect_val("rxp_rd1_rise", tp + 1);
      expect_val("rxp_rd1_fall", tp + 4);
      expect_val("rxp_rr1_rise", tp + 4);
      expect_val("rxp_rd0_quiet", -1);
      expect_val("rxp_rx_ready", 3);
      ticks(1);
      reset_rx_digital[1] = 1'b0;
      ticks(8);
      obs_q.push_back(rd_rise[1]);
      obs_q.push_back(rd_fall[1]);
      obs_q.push_back(rr_rise[1]);
      obs_q.push_back(rd_rise[0]);
      obs_q.push_back(32'(rx_ready));
      clear_events();
      reset_tx_digital = 1'b1;
      tt = cyc;
      expect_val("txp_txd_rise", tt + 1);
      expect_val("txp_txd_fall", tt + 4);
      expect_val("txp_rr0_no_fall", -1);
      expect_val("txp_rr1_no_fall", -1);
      expect_val("txp_tx_ready", 1);
      ticks(1);
      reset_tx_digital = 1'b0;
      ticks(8);
      obs_q.push_back(txd_rise);
      obs_q.push_back(txd_fall);
      obs_q.push_back(rr_fall[0]);
      obs_q.push_back(rr_fall[1]);
      obs_q.push_back(32'(tx_ready));
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         n_checks++;
         if (o !== e.val)
            $display("FAIL %s: observed %0d required %0d", e.name, $signed(o), $signed(e.val));
         else n_pass++;
      end
   endtask

   task automatic test_pll_loss();
      exp_t        e;
      logic [31:0] o;
      int          tc, tr;
      clear_events();
      pll_is_locked = 1'b0;
      tc = cyc;
      expect_val("pl_txr_fall", tc + 3);
      expect_val("pl_rr0_fall", tc + 4);
      expect_val("pl_rr1_fall", tc + 4);
      expect_val("pl_rx_analogreset", 3);
      expect_val("pl_rx_digitalreset", 3);
      ticks(6);
      obs_q.push_back(txr_fall);
      obs_q.push_back(rr_fall[0]);
      obs_q.push_back(rr_fall[1]);
      obs_q.push_back(32'(rx_analogreset));
      obs_q.push_back(32'(rx_digitalreset));
      // A request while not READY must be dropped, not replayed after recovery.
      reset_rx_digital = 2'b11;
      ticks(1);
      reset_rx_digital = 2'b00;
      ticks(2);
      clear_events();
      pll_is_locked = 1'b1;
      tr = cyc;
      expect_val("pl_rr0_recover", tr + 16);
      expect_val("pl_rr1_recover", tr + 16);
      expect_val("pl_no_replay0", -1);
      expect_val("pl_no_replay1", -1);
      ticks(25);
      obs_q.push_back(rr_rise[0]);
      obs_q.push_back(rr_rise[1]);
      obs_q.push_back(rr_fall[0]);
      obs_q.push_back(rr_fall[1]);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         n_checks++;
         if (o !== e.val)
            $display("FAIL %s: observed %0d required %0d", e.name, $signed(o), $signed(e.val));
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      exp_t        e;
      logic [31:0] o;
      reset_all = 1'b1;
      ticks(2);
      reset_all = 1'b0;
      // PLL stays locked: TX ready at +3, analog drops at +6, LTD hold spans +7..+16.
      ticks(10);
      expect_val("ltd_hold_tx_ready", 1);
      expect_val("ltd_hold_analog", 0);
      expect_val("ltd_hold_rx_ready", 0);
      obs_q.push_back(32'(tx_ready));
      obs_q.push_back(32'(rx_analogreset));
      obs_q.push_back(32'(rx_ready));
      reset_all = 1'b1;
      #1;
      expect_val("arst_pll_powerdown", 1);
      expect_val("arst_tx_digitalreset", 1);
      expect_val("arst_rx_analogreset", 3);
      expect_val("arst_rx_digitalreset", 3);
      expect_val("arst_tx_ready", 0);
      expect_val("arst_rx_ready", 0);
      obs_q.push_back(32'(pll_powerdown));
      obs_q.push_back(32'(tx_digitalreset));
      obs_q.push_back(32'(rx_analogreset));
      obs_q.push_back(32'(rx_digitalreset));
      obs_q.push_back(32'(tx_ready));
      obs_q.push_back(32'(rx_ready));
      ticks(2);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         n_checks++;
         if (o !== e.val)
            $display("FAIL %s: observed %0d required %0d", e.name, $signed(o), $signed(e.val));
         else n_pass++;
      end
   endtask

   initial begin
      clear_events();
      test_reset();
      test_bringup();
      test_oc_skew();
      test_lock_loss();
      test_manual();
      test_dig_pulse();
      test_pll_loss();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
